// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front-end: frame geometry, pixel width
// and the loader state encoding.
package cnn_pkg;

  localparam int IMG_W   = 28;
  localparam int IMG_H   = 28;
  localparam int PIX_W   = 8;
  localparam int IMG_PIX = IMG_W * IMG_H;
  localparam int CNT_W   = $clog2(IMG_PIX);

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT
  } loader_state_t;

endpackage

// File: rtl/pix_binarize.sv
// Combinational threshold compare turning one grayscale pixel into a 1-bit sample.
module pix_binarize
  import cnn_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH = PIX_W'(128)
) (
  input  logic [PIX_W-1:0] pix_i,
  output logic             bin_o
);

  assign bin_o = (pix_i >= THRESH);

endmodule

// File: rtl/image_loader.sv
// Loads a raster-order grayscale frame, binarises it into a 1-bit frame store and
// hands it to the convolution engine with a begin/done handshake.
module image_loader
  import cnn_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH = PIX_W'(128)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             image [0:IMG_PIX-1],
  output logic             begin_conv,
  input  logic             done_conv,
  output logic             busy,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_PIX - 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             drop_q, drop_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             done_q;
  logic             ready_q;
  logic             begin_q;
  logic             img_q [0:IMG_PIX-1];
  logic             xfer;
  logic             wr_en;
  logic             pix_bit;

  pix_binarize #(
    .THRESH (THRESH)
  ) u_bin (
    .pix_i (pix_data),
    .bin_o (pix_bit)
  );

  assign xfer = pix_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    drop_d  = drop_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (xfer) begin
          if (drop_q) begin
            // Tail of an over-long frame: swallow pixels until its last marker.
            if (pix_last) drop_d = 1'b0;
          end else begin
            wr_en  = 1'b1;
            busy_d = 1'b1;
            if (cnt_q == LAST_IDX) begin
              cnt_d = '0;
              if (pix_last) begin
                state_d = START;
              end else begin
                err_d  = 1'b1;
                drop_d = 1'b1;
              end
            end else if (pix_last) begin
              err_d  = 1'b1;
              cnt_d  = '0;
              busy_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done_conv && !done_q) begin
          fcnt_d  = fcnt_q + 16'd1;
          busy_d  = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control registers; ready and begin are registered views of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      begin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_conv;
      ready_q <= (state_d == LOAD);
      begin_q <= (state_d == START);
    end
  end

  // Frame store is flops so reset can clear it; only LOAD ever writes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_q <= '{default: 1'b0};
    end else if (wr_en) begin
      img_q[cnt_q] <= pix_bit;
    end
  end

  assign image      = img_q;
  assign pix_ready  = ready_q;
  assign begin_conv = begin_q;
  assign busy       = busy_q;
  assign frame_err  = err_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: a frame-level model tracks what the outputs
// must be after every clock edge and is compared on each falling edge.
module tb_image_loader;
  import cnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = 8'd0;
  logic        pix_last = 1'b0;
  logic        image [0:IMG_PIX-1];
  logic        begin_conv;
  logic        done_conv = 1'b0;
  logic        busy;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model of the loader's observable behaviour.
  bit m_img [0:IMG_PIX-1];
  bit m_ready, m_begin, m_waiting, m_busy, m_err, m_drop, m_done_prev;
  int m_idx, m_fcnt;

  image_loader dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .image      (image),
    .begin_conv (begin_conv),
    .done_conv  (done_conv),
    .busy       (busy),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < IMG_PIX; i++) m_img[i] = 1'b0;
    m_ready = 1; m_begin = 0; m_waiting = 0; m_busy = 0; m_err = 0;
    m_drop = 0; m_done_prev = 0; m_idx = 0; m_fcnt = 0;
  endtask

  task automatic model_accept(logic [7:0] d, logic last);
    if (m_drop) begin
      if (last) m_drop = 0;
      return;
    end
    m_img[m_idx] = (d >= 8'd128);
    m_busy = 1;
    if (last && m_idx == IMG_PIX - 1) begin
      m_idx = 0; m_begin = 1; m_ready = 0;
    end else if (last) begin
      m_err = 1; m_idx = 0; m_busy = 0;
    end else if (m_idx == IMG_PIX - 1) begin
      m_err = 1; m_idx = 0; m_drop = 1;
    end else begin
      m_idx++;
    end
  endtask

  // One clock edge: capture the inputs seen at the edge, then advance the model.
  task automatic tick();
    bit          xfer, rise;
    logic [7:0]  d;
    logic        l;
    xfer = pix_valid && m_ready;
    rise = done_conv && !m_done_prev;
    d = pix_data;
    l = pix_last;
    m_done_prev = done_conv;
    @(posedge clk);
    #1;
    m_err = 0;
    if (m_begin) begin
      m_begin = 0; m_waiting = 1;
    end else if (m_waiting) begin
      if (rise) begin
        m_waiting = 0; m_ready = 1; m_busy = 0; m_fcnt = (m_fcnt + 1) % 65536;
      end
    end else if (xfer) begin
      model_accept(d, l);
    end
  endtask

  function automatic logic [7:0] pix_val(int mode, int k);
    case (mode)
      0: return (k % 2) ? 8'd200 : 8'd50;
      1: begin
        if (k == 0) return 8'd127;
        if (k == 1) return 8'd128;
        if (k == 2) return 8'd255;
        if (k == 3) return 8'd0;
        return 8'((k * 37) % 256);
      end
      2: return (k < IMG_PIX) ? 8'd0 : 8'd255;
      default: return 8'd255;
    endcase
  endfunction

  task automatic send_frame(int n, int mode, int last_at, int err_at);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      pix_data  = pix_val(mode, k);
      pix_last  = (k == last_at);
      tick();
      if (k == err_at) chk("frame_err_lit", frame_err, 1);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic finish_conv();
    done_conv = 1'b1;
    tick();
    done_conv = 1'b0;
    tick();
  endtask

  task automatic reset_dut();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", pix_ready, 1);
    chk("rst_begin", begin_conv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_img5", image[5], 0);
    chk("rst_img783", image[783], 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin : compare
    int bad;
    if (chk_en) begin
      bad = -1;
      for (int i = 0; i < IMG_PIX; i++)
        if (image[i] !== m_img[i] && bad < 0) bad = i;
      chk("pix_ready", pix_ready, m_ready);
      chk("begin_conv", begin_conv, m_begin);
      chk("busy", busy, m_busy);
      chk("frame_err", frame_err, m_err);
      chk("frame_cnt", frame_cnt, m_fcnt);
      chk("image_first_bad_idx", bad, -1);
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("init_ready", pix_ready, 1);
    chk("init_fcnt", frame_cnt, 0);
    chk("init_busy", busy, 0);
    model_reset();
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Alternating full frame; pix_valid kept high into START/WAIT must be ignored.
    send_frame(IMG_PIX, 0, IMG_PIX - 1, -1);
    chk("begin_after_last", begin_conv, 1);
    pix_valid = 1'b1; pix_data = 8'd255; pix_last = 1'b1;
    tick();
    chk("begin_single", begin_conv, 0);
    chk("ready_wait", pix_ready, 0);
    tick();
    pix_valid = 1'b0; pix_last = 1'b0;
    tick();
    chk("img0_alt", image[0], 0);
    chk("img1_alt", image[1], 1);
    chk("img783_alt", image[783], 1);
    finish_conv();
    chk("fcnt_a", frame_cnt, 1);
    chk("ready_after_done", pix_ready, 1);

    // Threshold boundary frame.
    send_frame(IMG_PIX, 1, IMG_PIX - 1, -1);
    tick();
    chk("thr_127", image[0], 0);
    chk("thr_128", image[1], 1);
    chk("thr_255", image[2], 1);
    chk("thr_0", image[3], 0);
    finish_conv();
    chk("fcnt_thr", frame_cnt, 2);

    // Short frame then a good frame.
    send_frame(100, 0, 99, 99);
    chk("short_busy", busy, 0);
    tick();
    chk("short_no_begin", begin_conv, 0);
    send_frame(IMG_PIX, 3, IMG_PIX - 1, -1);
    tick();
    finish_conv();
    chk("fcnt_after_short", frame_cnt, 3);

    // Long frame: tail pixels of 255 must not reach the store.
    send_frame(790, 2, 789, 783);
    tick();
    chk("long_img0", image[0], 0);
    chk("long_img5", image[5], 0);
    chk("long_ready", pix_ready, 1);
    send_frame(IMG_PIX, 0, IMG_PIX - 1, -1);
    tick();
    finish_conv();
    chk("fcnt_after_long", frame_cnt, 4);

    // done_conv already high before START: only a fresh rise completes.
    done_conv = 1'b1;
    send_frame(IMG_PIX, 3, IMG_PIX - 1, -1);
    repeat (3) tick();
    chk("done_held_ready", pix_ready, 0);
    chk("done_held_fcnt", frame_cnt, 4);
    done_conv = 1'b0;
    tick();
    done_conv = 1'b1;
    tick();
    chk("done_rise_ready", pix_ready, 1);
    chk("done_rise_fcnt", frame_cnt, 5);
    done_conv = 1'b0;
    repeat (3) tick();
    chk("done_once_fcnt", frame_cnt, 5);

    // Reset mid-LOAD, then a fresh frame, then reset while in WAIT.
    send_frame(400, 3, -1, -1);
    reset_dut();
    send_frame(IMG_PIX, 0, IMG_PIX - 1, -1);
    repeat (2) tick();
    chk("wait_busy", busy, 1);
    reset_dut();
    send_frame(IMG_PIX, 1, IMG_PIX - 1, -1);
    tick();
    finish_conv();
    chk("fcnt_after_rst", frame_cnt, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Front-end stage that feeds the first convolution engine.
- Accepts a raster-order stream of 8-bit grayscale pixels over a valid/ready handshake.
- Binarises each pixel against a threshold and stores the 28x28 1-bit frame.
- Once the frame is complete, pulses begin_conv to the convolution engine, holds the image stable until the engine reports done, then accepts the next frame.

Parameters:
IMG_W, 28, image width in pixels
IMG_H, 28, image height in pixels
PIX_W, 8, input pixel width in bits
THRESH, 128, binarisation threshold; pixel >= THRESH stores 1, else 0

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
pix_valid  input  1  upstream pixel valid
pix_ready  output  1  loader can accept a pixel
pix_data  input  PIX_W  unsigned grayscale pixel
pix_last  input  1  marks final pixel of a frame
image  output  IMG_W*IMG_H x 1  unpacked 1-bit frame, index = row*IMG_W+col, ascending [0:IMG_W*IMG_H-1]
begin_conv  output  1  one-cycle start pulse to the convolution engine
done_conv  input  1  completion indication from the convolution engine
busy  output  1  high from the first accepted pixel until done is seen
frame_err  output  1  one-cycle pulse on a framing error
frame_cnt  output  16  completed frames, wraps at 2^16

Behaviour:
- Reset (asynchronous, immediate):
  - state=LOAD, pix_cnt=0, pix_ready=1, begin_conv=0, busy=0, frame_err=0, frame_cnt=0.
  - Every image bit=0. Reset clears the frame store, so reset drives the store as flops, not RAM.
- Handshake:
  - A transfer occurs on a clk edge where pix_valid && pix_ready.
  - pix_ready is a registered function of state only: 1 in LOAD, 0 otherwise. It never depends combinationally on pix_valid.
- FSM states: LOAD, START, WAIT.
- LOAD:
  - Each transfer writes image[pix_cnt] <= (pix_data >= THRESH) and increments pix_cnt (10 bits, 0..783).
  - busy goes high on the first transfer of a frame.
  - Transfer at pix_cnt==783 with pix_last=1: go to START, pix_cnt<=0.
  - Transfer with pix_last=1 at pix_cnt<783 (short frame): frame_err pulse, pix_cnt<=0, stay in LOAD, busy<=0. Stored bits are left as-is and are overwritten by the next frame.
  - Transfer at pix_cnt==783 with pix_last=0 (long frame): frame_err pulse, pix_cnt<=0, stay in LOAD. Subsequent pixels until and including the next pix_last are discarded: an internal drop flag is set, pix_ready stays 1, and writes are suppressed. The flag clears on the pix_last transfer.
- START:
  - Lasts exactly one cycle. begin_conv=1 (registered), pix_ready=0. Next state is WAIT.
- WAIT:
  - pix_ready=0; image is held constant.
  - done_conv is registered into done_q. Completion is the rising edge done_conv && !done_q, and is evaluated only in WAIT.
  - Any level of done_conv present in START is ignored.
  - On completion: frame_cnt+1, busy<=0, state<=LOAD, pix_ready=1 from the next cycle.
- Latency:
  - Last accepted pixel at edge N: begin_conv high during cycle N+1 (after edge N), WAIT from edge N+1.
  - done_conv rising edge seen at edge M: pix_ready high after edge M.
- Simultaneous events:
  - pix_valid in START/WAIT is ignored; no transfer, since ready=0.
  - done_conv outside WAIT has no effect beyond updating done_q.
- Reset mid-operation (any state): immediate return to the reset values. A begin_conv already issued is not retracted; the downstream engine is reset by the same rst at system level.
- The image output must be stable from START through leaving WAIT, because the convolution engine reads it combinationally for its whole run.

Decomposition:
- Shared package cnn_pkg:
  - IMG_W/IMG_H/PIX_W constants and IMG_PIX = IMG_W*IMG_H.
  - typedef enum logic [1:0] {LOAD, START, WAIT} loader_state_t.
  - Pixel-count width localparam $clog2(IMG_PIX).
- One natural sub-module: pix_binarize, a combinational threshold compare, reused by later grayscale inputs.
- The frame store stays inline.

Test Plan:
- Full frame, pixel k = (k%2 ? 200 : 50), last on k=783:
  - image[k]=k%2.
  - begin_conv single pulse exactly 1 cycle after the final transfer.
  - pix_ready=0 until the done_conv rise; frame_cnt=1.
- Threshold boundary, pixels 127, 128, 255, 0 at indices 0..3: image[0..3]=0,1,1,0.
- Short frame, pix_last on index 99: frame_err pulse, no begin_conv, busy=0. A following valid 784-pixel frame then completes normally with frame_cnt=1.
- Long frame, 790 pixels with last on the 790th: frame_err at index 783. Pixels 784..789 are accepted but not written; the next frame starts at index 0.
- done_conv held high before and through START: no premature return to LOAD. Drop done_conv, then raise it: return to LOAD once, frame_cnt increments by exactly 1.
- Assert rst mid-LOAD at pix_cnt=400 and again in WAIT: outputs match the reset values immediately (asynchronous). The next frame loads from index 0.
